// File: rtl/booth_r4_mac_seq.sv
// booth_r4_mac_seq
// Sequential radix-4 Booth multiply-accumulate. One Booth digit is retired per
// clock through a single (W+2)-bit add/subtract stage. The 2W-bit product is
// either loaded into, or added onto, a wide running accumulator.
module booth_r4_mac_seq #(
  parameter int W     = 8,
  parameter int ACC_W = 2*W+4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic               accumulate,
  output logic               busy,
  output logic               done,
  output logic [2*W-1:0]     product,
  output logic [ACC_W-1:0]   acc
);

  localparam int ITER = W/2;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ITER-1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Booth digit decode: returns {negate, magnitude}. The magnitude is 0, M or
  // 2M; negation is applied in the adder as ~pp + 1.
  function automatic logic [W+2:0] booth_pp(input logic [2:0] trip,
                                            input logic [W+1:0] m);
    case (trip)
      3'b000, 3'b111: booth_pp = {1'b0, {(W+2){1'b0}}};
      3'b001, 3'b010: booth_pp = {1'b0, m};
      3'b011:         booth_pp = {1'b0, m[W:0], 1'b0};
      3'b100:         booth_pp = {1'b1, m[W:0], 1'b0};
      3'b101, 3'b110: booth_pp = {1'b1, m};
      default:        booth_pp = {1'b0, {(W+2){1'b0}}};
    endcase
  endfunction

  state_t             state_r, state_nxt_s;
  logic [CW-1:0]      cnt_r;
  logic [W+1:0]       m_r;       // sign-extended multiplicand
  logic [W+1:0]       a_r;       // partial-sum (high) register
  logic [W-1:0]       q_r;       // multiplier / low product bits
  logic               qm1_r;     // Booth guard bit
  logic               mode_r;
  logic               busy_r;
  logic               done_r;
  logic [2*W-1:0]     product_r;
  logic [ACC_W-1:0]   acc_r;

  logic               load_s;
  logic               iter_s;
  logic               last_s;
  logic [W+2:0]       sel_s;
  logic               neg_s;
  logic [W+1:0]       pp_s;
  logic [W+1:0]       sum_s;
  logic [W+1:0]       a_new_s;
  logic [W-1:0]       q_new_s;
  logic               qm1_new_s;
  logic [2*W-1:0]     product_s;
  logic [ACC_W-1:0]   prod_ext_s;
  logic [ACC_W-1:0]   acc_new_s;

  // Next-state and control decode for the IDLE/CALC controller.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    iter_s      = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = CALC;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        iter_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          last_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // One Booth step: add/subtract the selected multiple, then shift right by two
  // with the sign of the new partial sum replicated into the top.
  always_comb begin
    sel_s      = booth_pp({q_r[1], q_r[0], qm1_r}, m_r);
    neg_s      = sel_s[W+2];
    pp_s       = neg_s ? ~sel_s[W+1:0] : sel_s[W+1:0];
    sum_s      = a_r + pp_s + {{(W+1){1'b0}}, neg_s};
    a_new_s    = {{2{sum_s[W+1]}}, sum_s[W+1:2]};
    q_new_s    = {sum_s[1:0], q_r[W-1:2]};
    qm1_new_s  = q_r[1];
    product_s  = {sum_s, q_r[W-1:2]};
    prod_ext_s = ACC_W'($signed(product_s));
    if (mode_r) begin
      acc_new_s = acc_r + prod_ext_s;
    end else begin
      acc_new_s = prod_ext_s;
    end
  end

  // Controller state, busy flag and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == CALC);
      done_r  <= last_s;
    end
  end

  // Operand capture and iterative Booth datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r    <= '0;
      a_r    <= '0;
      q_r    <= '0;
      qm1_r  <= 1'b0;
      mode_r <= 1'b0;
      cnt_r  <= '0;
    end else if (load_s) begin
      m_r    <= {{2{a[W-1]}}, a};
      a_r    <= '0;
      q_r    <= b;
      qm1_r  <= 1'b0;
      mode_r <= accumulate;
      cnt_r  <= '0;
    end else if (iter_s) begin
      a_r    <= a_new_s;
      q_r    <= q_new_s;
      qm1_r  <= qm1_new_s;
      cnt_r  <= cnt_r + CW'(1);
    end else begin
      a_r    <= a_r;
      q_r    <= q_r;
      qm1_r  <= qm1_r;
      cnt_r  <= cnt_r;
    end
  end

  // Result registers: update only on the final Booth iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_r <= '0;
      acc_r     <= '0;
    end else if (last_s) begin
      product_r <= product_s;
      acc_r     <= acc_new_s;
    end else begin
      product_r <= product_r;
      acc_r     <= acc_r;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;
  assign acc     = acc_r;

endmodule
